// File: rtl/dcache_write_buffer_if.sv
// Cache-side and memory-side signal bundle for the D-cache posted-write buffer.
// Latency: none; this file only groups wires.
// Backpressure: c_ready paces the cache, mem_ready paces the buffer's memory requests.
interface dcache_write_buffer_if;
  logic         c_read;
  logic         c_write;
  logic [27:0]  c_addr;
  logic [127:0] c_wdata;
  logic [127:0] c_rdata;
  logic         c_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         wbuf_empty;

  // Cache plus slow-memory side (drives requests and memory responses)
  modport master (
    output c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
    input  c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata, wbuf_empty
  );

  // Write buffer side
  modport slave (
    input  c_read, c_write, c_addr, c_wdata, mem_rdata, mem_ready,
    output c_rdata, c_ready, mem_read, mem_write, mem_addr, mem_wdata, wbuf_empty
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted-write line buffer between D-cache and slow memory; reads hit buffered lines or bypass drains.
// Latency: write accept and read hit complete 1 cycle after request; read miss completes 1 cycle after mem_ready.
// Backpressure: writes stall while full; memory requests are held until mem_ready. Optional: WBUF_COALESCE_EN.
module dcache_write_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_write_buffer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t             state, state_nxt;
  logic [27:0]        ent_addr [DEPTH];
  logic [127:0]       ent_data [DEPTH];
  logic [DEPTH-1:0]   ent_vld;
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count, count_nxt;

  logic               c_ready_q;
  logic [127:0]       c_rdata_q;
  logic               mem_read_q, mem_write_q;
  logic [27:0]        mem_addr_q;
  logic [127:0]       mem_wdata_q;
  logic               wbuf_empty_q;

  logic               mem_read_nxt, mem_write_nxt;
  logic [27:0]        mem_addr_nxt;
  logic [127:0]       mem_wdata_nxt;

  logic               rd_hit;
  logic [127:0]       hit_data;
  logic [PTR_W-1:0]   scan_idx;
  logic               co_hit;
  logic [PTR_W-1:0]   co_idx;

  logic req_ok, wr_req, rd_req;
  logic wr_alloc, wr_coal, rd_hit_acc, rd_miss;
  logic drain_start, read_start, pop, read_done;

  assign bus.c_ready    = c_ready_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wbuf_empty = wbuf_empty_q;

  // Read lookup: scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    rd_hit   = 1'b0;
    hit_data = '0;
    scan_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (ent_vld[scan_idx] && (ent_addr[scan_idx] == bus.c_addr)) begin
        rd_hit   = 1'b1;
        hit_data = ent_data[scan_idx];
      end
    end
  end

  // The request is ignored during its own c_ready cycle so it is never accepted twice
  assign req_ok      = !c_ready_q;
  assign wr_req      = bus.c_write && req_ok;
  assign rd_req      = bus.c_read && req_ok;
  assign rd_hit_acc  = rd_req && rd_hit;
  assign rd_miss     = rd_req && !rd_hit;
  assign read_start  = (state == IDLE) && rd_miss;
  assign drain_start = (state == IDLE) && !rd_miss && (count != '0);
  assign pop         = (state == DRAIN) && bus.mem_ready;
  assign read_done   = (state == READ) && bus.mem_ready;
  assign wr_coal     = wr_req && co_hit;
  assign wr_alloc    = wr_req && !co_hit && (count < FULL_CNT);
  assign count_nxt   = count + (PTR_W+1)'(wr_alloc) - (PTR_W+1)'(pop);

`ifdef WBUF_COALESCE_EN
  // The head counts as in-drain from the cycle its drain is launched, so its data is never changed after capture
  logic drain_busy;
  assign drain_busy = (state == DRAIN) || drain_start;

  // Coalescing lookup: any valid entry other than the one being drained
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == bus.c_addr) && !(drain_busy && (PTR_W'(i) == head))) begin
        co_hit = 1'b1;
        co_idx = PTR_W'(i);
      end
    end
  end
`else
  // Coalescing disabled: every write allocates
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
  end
`endif

  // Memory FSM state and registered memory-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_nxt;
      mem_read_q  <= mem_read_nxt;
      mem_write_q <= mem_write_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
    end
  end

  // Next state: read misses beat drains; always return to IDLE after a transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (read_start)       state_nxt = READ;
        else if (drain_start) state_nxt = DRAIN;
      end
      DRAIN:   if (bus.mem_ready) state_nxt = IDLE;
      READ:    if (bus.mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port outputs: launch from IDLE, hold until mem_ready, then drop the strobe
  always_comb begin
    mem_read_nxt  = mem_read_q;
    mem_write_nxt = mem_write_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    case (state)
      IDLE: begin
        if (read_start) begin
          mem_read_nxt = 1'b1;
          mem_addr_nxt = bus.c_addr;
        end else if (drain_start) begin
          mem_write_nxt = 1'b1;
          mem_addr_nxt  = ent_addr[head];
          mem_wdata_nxt = ent_data[head];
        end
      end
      DRAIN:   if (bus.mem_ready) mem_write_nxt = 1'b0;
      READ:    if (bus.mem_ready) mem_read_nxt = 1'b0;
      default: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase
  end

  // Entry bookkeeping: allocate at tail, retire at head on drain completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_vld      <= '0;
      wbuf_empty_q <= 1'b1;
    end else begin
      if (wr_alloc) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      count        <= count_nxt;
      wbuf_empty_q <= (count_nxt == '0);
    end
  end

  // Entry payload storage; contents are only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      ent_addr[tail] <= bus.c_addr;
      ent_data[tail] <= bus.c_wdata;
    end
    if (wr_coal) begin
      ent_data[co_idx] <= bus.c_wdata;
    end
  end

  // Cache completion pulse and returned line data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready_q <= 1'b0;
      c_rdata_q <= '0;
    end else begin
      c_ready_q <= wr_alloc || wr_coal || rd_hit_acc || read_done;
      if (rd_hit_acc)     c_rdata_q <= hit_data;
      else if (read_done) c_rdata_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Randomized and directed bench for dcache_write_buffer against a queue-based reference model.
// Latency: the model predicts every registered output cycle by cycle from sampled inputs.
// Backpressure: a behavioural slow memory answers requests after a programmable random delay.
module tb_dcache_write_buffer;
  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  initial forever #5 clk = ~clk;

  dcache_write_buffer_if bus();

  dcache_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [27:0] a; logic [127:0] d; } ent_t;
  typedef struct { logic w; logic [27:0] a; logic [127:0] d; } mtx_t;

  ent_t q[$];
  mtx_t mlog[$];
  int   m_busy;  // 0 none, 1 write in flight, 2 read in flight

  logic         exp_c_ready, exp_mem_read, exp_mem_write, exp_empty;
  logic [127:0] exp_c_rdata, exp_mem_wdata;
  logic [27:0]  exp_mem_addr;

  int  lat_min = 0;
  int  lat_max = 0;
  int  wcnt = -1;
  logic saw_rd = 1'b0;

  function automatic logic [127:0] rd_pat(input logic [27:0] a);
    return {a, 4'hA, ~a, 4'h5, a, 4'h3, ~a, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy        = 0;
    exp_c_ready   = 1'b0;
    exp_c_rdata   = '0;
    exp_mem_read  = 1'b0;
    exp_mem_write = 1'b0;
    exp_mem_addr  = '0;
    exp_mem_wdata = '0;
    exp_empty     = 1'b1;
  endtask

  // One clock of the reference: buffer is a queue, memory side is a busy flag
  task automatic model_step();
    logic req_ok, wr, rd, hit, miss, dstart, pop, rdone, coal, alloc;
    logic [127:0] hd;
    int   ci, n;
    ent_t e;
    n      = q.size();
    req_ok = !exp_c_ready;
    wr     = bus.c_write && req_ok;
    rd     = bus.c_read && req_ok;
    hit    = 1'b0;
    hd     = '0;
    foreach (q[i]) if (q[i].a == bus.c_addr) begin hit = 1'b1; hd = q[i].d; end
    miss   = rd && !hit;
    dstart = (m_busy == 0) && !miss && (n > 0);
    pop    = (m_busy == 1) && bus.mem_ready;
    rdone  = (m_busy == 2) && bus.mem_ready;
    ci     = -1;
`ifdef WBUF_COALESCE_EN
    foreach (q[i]) if (q[i].a == bus.c_addr && !(i == 0 && (m_busy == 1 || dstart))) ci = i;
`endif
    coal  = wr && (ci >= 0);
    alloc = wr && (ci < 0) && (n < DEPTH);
    exp_c_ready = coal || alloc || (rd && hit) || rdone;
    if (rd && hit)  exp_c_rdata = hd;
    else if (rdone) exp_c_rdata = bus.mem_rdata;
    if (m_busy == 0) begin
      if (miss) begin
        m_busy = 2; exp_mem_read = 1'b1; exp_mem_addr = bus.c_addr;
      end else if (n > 0) begin
        m_busy = 1; exp_mem_write = 1'b1; exp_mem_addr = q[0].a; exp_mem_wdata = q[0].d;
      end
    end else if (bus.mem_ready) begin
      m_busy = 0; exp_mem_read = 1'b0; exp_mem_write = 1'b0;
    end
    if (coal) q[ci].d = bus.c_wdata;
    if (pop) q.delete(0);
    if (alloc) begin e.a = bus.c_addr; e.d = bus.c_wdata; q.push_back(e); end
    exp_empty = (q.size() == 0);
  endtask

  // Reference model clocking
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_read) saw_rd = 1'b1;
      if (rst_n) begin
        chk("c_ready",    128'(bus.c_ready),    128'(exp_c_ready));
        chk("c_rdata",    bus.c_rdata,          exp_c_rdata);
        chk("mem_read",   128'(bus.mem_read),   128'(exp_mem_read));
        chk("mem_write",  128'(bus.mem_write),  128'(exp_mem_write));
        chk("mem_addr",   128'(bus.mem_addr),   128'(exp_mem_addr));
        chk("mem_wdata",  bus.mem_wdata,        exp_mem_wdata);
        chk("wbuf_empty", 128'(bus.wbuf_empty), 128'(exp_empty));
      end
    end
  end

  // Slow memory: random delay, one-cycle ready pulse, logs each completed transfer
  initial begin
    mtx_t t;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_ready = 1'b0; wcnt = -1;
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0; wcnt = -1;
      end else if (bus.mem_read || bus.mem_write) begin
        if (wcnt < 0) wcnt = int'($urandom_range(lat_max, lat_min));
        if (wcnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_read ? rd_pat(bus.mem_addr) : {$urandom, $urandom, $urandom, $urandom};
          t.w = bus.mem_write; t.a = bus.mem_addr; t.d = bus.mem_wdata;
          mlog.push_back(t);
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Cache request: called at a negedge; holds through the c_ready cycle, returns at the following negedge
  task automatic cache_req(input logic is_wr, input logic [27:0] a, input logic [127:0] d,
                           output int lat, output logic [127:0] rd);
    bus.c_write = is_wr;
    bus.c_read  = !is_wr;
    bus.c_addr  = a;
    bus.c_wdata = d;
    lat = 0;
    rd  = '0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.c_ready) break;
      if (lat > 300) begin
        checks++; errors++;
        $display("FAIL cache_req_timeout: no c_ready after %0d cycles for addr %h", lat, a);
        break;
      end
    end
    rd = bus.c_rdata;
    @(negedge clk);
    bus.c_write = 1'b0;
    bus.c_read  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (bus.wbuf_empty && !bus.mem_write && !bus.mem_read) break;
      @(negedge clk);
    end
    if (i == 1000) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: buffer still busy after %0d cycles", name, i);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat3;
    logic [127:0] rd;
    logic [27:0]  a;
    logic [127:0] d;
    bus.c_read = 1'b0; bus.c_write = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;

    // Reset, then idle
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_c_ready",   128'(bus.c_ready), 128'(0));
    chk("rst_c_rdata",   bus.c_rdata, 128'(0));
    chk("rst_mem_read",  128'(bus.mem_read), 128'(0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_mem_addr",  128'(bus.mem_addr), 128'(0));
    chk("rst_empty",     128'(bus.wbuf_empty), 128'(1));

    // Single write with 8-cycle memory
    lat_min = 8; lat_max = 8; mlog.delete();
    cache_req(1'b1, 28'h0000010, 128'hA, lat, rd);
    chk_int("t2_wr_lat", lat, 1);
    chk("t2_drain_started", 128'(bus.mem_write), 128'(1));
    chk("t2_drain_addr",    128'(bus.mem_addr), 128'(28'h10));
    chk("t2_drain_data",    bus.mem_wdata, 128'hA);
    wait_idle("t2");
    chk("t2_empty_after", 128'(bus.wbuf_empty), 128'(1));
    chk_int("t2_log_size", mlog.size(), 1);

    // Three back-to-back writes into a 2-deep buffer
    lat_min = 10; lat_max = 10; mlog.delete();
    cache_req(1'b1, 28'h10, 128'h1111, lat, rd);
    chk_int("t3_w1_lat", lat, 1);
    cache_req(1'b1, 28'h20, 128'h2222, lat, rd);
    chk_int("t3_w2_lat", lat, 1);
    cache_req(1'b1, 28'h30, 128'h3333, lat3, rd);
    chk_int("t3_w3_held", int'(lat3 > 1), 1);
    wait_idle("t3");
    chk_int("t3_log_size", mlog.size(), 3);
    if (mlog.size() == 3) begin
      chk("t3_order0", 128'(mlog[0].a), 128'(28'h10));
      chk("t3_order1", 128'(mlog[1].a), 128'(28'h20));
      chk("t3_order2", 128'(mlog[2].a), 128'(28'h30));
    end

    // Read hit on a buffered line
    lat_min = 6; lat_max = 6; mlog.delete(); saw_rd = 1'b0;
    cache_req(1'b1, 28'h40, 128'hBBBB_0000_BBBB, lat, rd);
    cache_req(1'b0, 28'h40, '0, lat, rd);
    chk_int("t4_hit_lat", lat, 1);
    chk("t4_hit_data", rd, 128'hBBBB_0000_BBBB);
    wait_idle("t4");
    chk("t4_no_mem_read", 128'(saw_rd), 128'(0));

    // Read miss overtakes a pending drain
    mlog.delete();
    cache_req(1'b1, 28'h48, 128'h4848, lat, rd);
    cache_req(1'b1, 28'h50, 128'h5050, lat, rd);
    cache_req(1'b0, 28'h60, '0, lat, rd);
    chk("t5_miss_data", rd, rd_pat(28'h60));
    wait_idle("t5");
    chk_int("t5_log_size", mlog.size(), 3);
    if (mlog.size() == 3) begin
      chk("t5_first",  {mlog[0].w, 99'(0), mlog[0].a}, {1'b1, 99'(0), 28'h48});
      chk("t5_second", {mlog[1].w, 99'(0), mlog[1].a}, {1'b0, 99'(0), 28'h60});
      chk("t5_third",  {mlog[2].w, 99'(0), mlog[2].a}, {1'b1, 99'(0), 28'h50});
    end

    // Repeated write to one line while memory is busy
    mlog.delete();
    cache_req(1'b1, 28'h68, 128'hF0F0, lat, rd);
    cache_req(1'b1, 28'h70, 128'hC0C0, lat, rd);
    cache_req(1'b1, 28'h70, 128'hD0D0, lat, rd);
`ifdef WBUF_COALESCE_EN
    chk_int("t6_coalesce_lat", lat, 1);
`else
    chk_int("t6_full_wait", int'(lat > 1), 1);
`endif
    cache_req(1'b0, 28'h70, '0, lat, rd);
    chk("t6_read_newest", rd, 128'hD0D0);
    wait_idle("t6");
`ifdef WBUF_COALESCE_EN
    chk_int("t6_log_size", mlog.size(), 2);
    if (mlog.size() == 2) chk("t6_last_data", mlog[1].d, 128'hD0D0);
`else
    chk_int("t6_log_size", mlog.size(), 3);
    if (mlog.size() == 3) begin
      chk("t6_c_data", mlog[1].d, 128'hC0C0);
      chk("t6_d_data", mlog[2].d, 128'hD0D0);
    end
`endif

    // Reset in the middle of a drain
    lat_min = 20; lat_max = 20;
    cache_req(1'b1, 28'h80, 128'h8080, lat, rd);
    chk("t7_draining", 128'(bus.mem_write), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("t7_rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("t7_rst_empty",     128'(bus.wbuf_empty), 128'(1));
    chk("t7_rst_mem_addr",  128'(bus.mem_addr), 128'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic over a small address set so hits, misses and repeats are frequent
    lat_min = 0; lat_max = 4;
    for (int n = 0; n < 400; n++) begin
      a = 28'h100 + 28'($urandom_range(7, 0)) * 28'h10;
      d = {$urandom, $urandom, $urandom, $urandom};
      cache_req($urandom_range(1, 0) == 1, a, d, lat, rd);
      if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    wait_idle("rand");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
